// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bundle: PC block, instruction memory and decode-side signals
interface fetch_unit_if #(
  parameter int AW = 32,
  parameter int IW = 32
);
  logic [AW-1:0] pc_in;
  logic          pc_advance;
  logic          redirect;
  logic          mem_enable;
  logic          mem_rw;
  logic          mem_ack;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_data_out;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic          fetch_fault;

  modport master (
    input  pc_in, redirect, mem_ack, mem_data_out, inst_ready,
    output pc_advance, mem_enable, mem_rw, mem_addr, inst, inst_pc, inst_valid, fetch_fault
  );

  modport slave (
    output pc_in, redirect, mem_ack, mem_data_out, inst_ready,
    input  pc_advance, mem_enable, mem_rw, mem_addr, inst, inst_pc, inst_valid, fetch_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetcher feeding a 2-entry instruction queue
// Optional misaligned-PC fault detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter int AW = 32,
  parameter int IW = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_mem_enable;
  logic [AW-1:0] r_mem_addr;
  logic [AW-1:0] r_q_pc   [2];
  logic [IW-1:0] r_q_inst [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;

  logic w_push;
  logic w_pop;
  logic w_can_issue;
  logic w_misaligned;
  logic w_fault;

  // A redirect kills both the in-flight push and any pop of stale entries.
  assign w_push      = (r_state == REQ) && bus.mem_ack && !bus.redirect;
  assign w_pop       = (r_count != 2'd0) && bus.inst_ready && !bus.redirect;
  assign w_can_issue = (r_count <= 2'd1) && !bus.redirect && !w_fault;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;

  assign w_misaligned = |bus.pc_in[1:0];
  assign w_fault      = r_fault;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fault <= 1'b0;
    end else if (bus.redirect) begin
      r_fault <= 1'b0;
    end else if ((r_state == IDLE) && w_can_issue && w_misaligned) begin
      r_fault <= 1'b1;
    end
  end
`else
  assign w_misaligned = 1'b0;
  assign w_fault      = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_mem_enable <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_can_issue && !w_misaligned) begin
            r_state      <= REQ;
            r_mem_enable <= 1'b1;
            r_mem_addr   <= bus.pc_in;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            r_state      <= IDLE;
            r_mem_enable <= 1'b0;
          end else if (bus.redirect) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // The abandoned request must still complete before a new one may start.
          if (bus.mem_ack) begin
            r_state      <= IDLE;
            r_mem_enable <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_mem_enable <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_q_pc[i]   <= '0;
        r_q_inst[i] <= '0;
      end
    end else if (bus.redirect) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_q_pc[r_wr_ptr]   <= r_mem_addr;
        r_q_inst[r_wr_ptr] <= bus.mem_data_out;
        r_wr_ptr           <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign bus.pc_advance  = w_push;
  assign bus.mem_enable  = r_mem_enable;
  assign bus.mem_rw      = 1'b0;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.inst        = r_q_inst[r_rd_ptr];
  assign bus.inst_pc     = r_q_pc[r_rd_ptr];
  assign bus.inst_valid  = (r_count != 2'd0);
  assign bus.fetch_fault = w_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a wait-state memory and PC model
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  logic clk;
  logic reset;

  fetch_unit_if #(.AW(32), .IW(32)) bus ();

  fetch_unit #(.AW(32), .IW(32)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  entry_t      sb[$];
  logic [31:0] pc_model;
  logic [31:0] redir_target;
  int          mem_wait;
  int          wcnt;
  bit          drain;
  bit          tb_redirect;
  bit          tb_ready;
  bit          tb_force_ack;
  logic        s_adv, s_en, s_valid, s_fault;
  logic [31:0] s_addr, s_inst_pc;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  // One clock cycle: memory/PC model drive, negedge sample, scoreboard update.
  task automatic cycle();
    bit     real_ack;
    bit     exp_adv;
    entry_t e;
    real_ack = 1'b0;
    if (bus.mem_enable === 1'b1) begin
      if (wcnt >= mem_wait) begin
        real_ack = 1'b1;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    bus.pc_in        = pc_model;
    bus.redirect     = tb_redirect;
    bus.inst_ready   = tb_ready;
    bus.mem_ack      = real_ack | tb_force_ack;
    bus.mem_data_out = mem_fn(bus.mem_addr);
    @(negedge clk);
    s_adv     = bus.pc_advance;
    s_en      = bus.mem_enable;
    s_valid   = bus.inst_valid;
    s_fault   = bus.fetch_fault;
    s_addr    = bus.mem_addr;
    s_inst_pc = bus.inst_pc;
    exp_adv   = real_ack && !tb_redirect && !drain;
    checks++;
    if (s_adv !== exp_adv) begin
      failures++;
      $display("FAIL pc_advance: got %b expected %b at %0t", s_adv, exp_adv, $time);
    end
    checks++;
    if (bus.mem_rw !== 1'b0) begin
      failures++;
      $display("FAIL mem_rw: got %b expected 0 at %0t", bus.mem_rw, $time);
    end
    if (s_en === 1'b1 && !drain) begin
      checks++;
      if (s_addr !== pc_model) begin
        failures++;
        $display("FAIL mem_addr: got %h expected %h at %0t", s_addr, pc_model, $time);
      end
    end
    checks++;
    if (s_valid !== (sb.size() != 0)) begin
      failures++;
      $display("FAIL inst_valid: got %b expected %b at %0t", s_valid, (sb.size() != 0), $time);
    end
    if (sb.size() != 0) begin
      checks++;
      if (s_inst_pc !== sb[0].pc || bus.inst !== sb[0].data) begin
        failures++;
        $display("FAIL queue_head: got pc %h inst %h expected pc %h inst %h at %0t",
                 s_inst_pc, bus.inst, sb[0].pc, sb[0].data, $time);
      end
    end
    if (tb_redirect) begin
      sb.delete();
      pc_model = redir_target;
    end else begin
      if (sb.size() != 0 && tb_ready) void'(sb.pop_front());
      if (exp_adv) begin
        e.pc   = pc_model;
        e.data = mem_fn(pc_model);
        sb.push_back(e);
        pc_model = pc_model + 32'd4;
      end
    end
    if (real_ack) drain = 1'b0;
    else if (s_en === 1'b1 && tb_redirect) drain = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [31:0] start);
    reset          = 1'b1;
    tb_redirect    = 1'b0;
    tb_ready       = 1'b0;
    tb_force_ack   = 1'b0;
    bus.redirect   = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.inst_ready = 1'b0;
    bus.pc_in      = start;
    @(posedge clk);
    #1;
    sb.delete();
    drain    = 1'b0;
    wcnt     = 0;
    pc_model = start;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.pc_in        = 32'h100;
    bus.mem_ack      = 1'b1;
    bus.mem_data_out = 32'hDEAD_BEEF;
    bus.inst_ready   = 1'b1;
    bus.redirect     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.mem_enable, bus.pc_advance, bus.inst_valid, bus.fetch_fault} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {bus.mem_enable, bus.pc_advance, bus.inst_valid, bus.fetch_fault});
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: got addr %h inst %h pc %h expected 0", bus.mem_addr, bus.inst, bus.inst_pc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_wait();
    logic        adv[5];
    logic        val[5];
    logic [31:0] ipc[5];
    apply_reset(32'h0);
    mem_wait = 0;
    tb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      adv[i] = s_adv;
      val[i] = s_valid;
      ipc[i] = s_inst_pc;
    end
    checks++;
    if ({adv[0], adv[1], adv[2], adv[3], adv[4]} !== 5'b01010) begin
      failures++;
      $display("FAIL zero_wait_adv: got %b expected 01010", {adv[0], adv[1], adv[2], adv[3], adv[4]});
    end
    checks++;
    if (val[2] !== 1'b1 || ipc[2] !== 32'h0) begin
      failures++;
      $display("FAIL zero_wait_c2: got valid %b pc %h expected 1 0", val[2], ipc[2]);
    end
    checks++;
    if (val[4] !== 1'b1 || ipc[4] !== 32'h4) begin
      failures++;
      $display("FAIL zero_wait_c4: got valid %b pc %h expected 1 4", val[4], ipc[4]);
    end
  endtask

  task automatic test_backpressure();
    int n_adv;
    bit en_seen;
    apply_reset(32'h0);
    mem_wait = 0;
    tb_ready = 1'b0;
    n_adv    = 0;
    en_seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_adv === 1'b1) n_adv++;
      if (i >= 5 && s_en !== 1'b0) en_seen = 1'b1;
    end
    checks++;
    if (n_adv != 2) begin
      failures++;
      $display("FAIL bp_pushes: got %0d expected 2", n_adv);
    end
    checks++;
    if (en_seen) begin
      failures++;
      $display("FAIL bp_enable_full: got 1 expected 0");
    end
    checks++;
    if (s_valid !== 1'b1 || s_inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL bp_head: got valid %b pc %h expected 1 0", s_valid, s_inst_pc);
    end
    tb_ready = 1'b1;
    cycle();
    tb_ready = 1'b0;
    cycle();
    checks++;
    if (s_en !== 1'b0) begin
      failures++;
      $display("FAIL bp_issue_decide: got %b expected 0", s_en);
    end
    cycle();
    checks++;
    if (s_en !== 1'b1 || s_addr !== 32'h8) begin
      failures++;
      $display("FAIL bp_reissue: got en %b addr %h expected 1 8", s_en, s_addr);
    end
  endtask

  task automatic test_redirect_drain();
    int n_adv;
    apply_reset(32'h8);
    mem_wait     = 3;
    tb_ready     = 1'b1;
    redir_target = 32'h40;
    n_adv        = 0;
    for (int i = 0; i < 11; i++) begin
      tb_redirect = (i == 1);
      cycle();
      if (s_adv === 1'b1) n_adv++;
      if (i == 2 || i == 3) begin
        checks++;
        if (s_en !== 1'b1 || s_addr !== 32'h8) begin
          failures++;
          $display("FAIL drain_hold: got en %b addr %h expected 1 8 (cycle %0d)", s_en, s_addr, i);
        end
      end
      if (i == 6) begin
        checks++;
        if (s_en !== 1'b1 || s_addr !== 32'h40) begin
          failures++;
          $display("FAIL drain_newreq: got en %b addr %h expected 1 40", s_en, s_addr);
        end
      end
      if (i == 10) begin
        checks++;
        if (s_valid !== 1'b1 || s_inst_pc !== 32'h40) begin
          failures++;
          $display("FAIL drain_result: got valid %b pc %h expected 1 40", s_valid, s_inst_pc);
        end
      end
    end
    tb_redirect = 1'b0;
    checks++;
    if (n_adv != 1) begin
      failures++;
      $display("FAIL drain_adv_count: got %0d expected 1", n_adv);
    end
  endtask

  task automatic test_redirect_ack();
    apply_reset(32'h0);
    mem_wait     = 0;
    tb_ready     = 1'b0;
    redir_target = 32'h20;
    for (int i = 0; i < 5; i++) begin
      tb_redirect = (i == 3);
      cycle();
      if (i == 2) begin
        checks++;
        if (s_valid !== 1'b1 || s_inst_pc !== 32'h0) begin
          failures++;
          $display("FAIL redir_ack_pre: got valid %b pc %h expected 1 0", s_valid, s_inst_pc);
        end
      end
      if (i == 3) begin
        checks++;
        if (s_en !== 1'b1 || s_adv !== 1'b0) begin
          failures++;
          $display("FAIL redir_ack_cycle: got en %b adv %b expected 1 0", s_en, s_adv);
        end
      end
      if (i == 4) begin
        checks++;
        if (s_valid !== 1'b0) begin
          failures++;
          $display("FAIL redir_ack_flush: got %b expected 0", s_valid);
        end
      end
    end
    tb_redirect = 1'b0;
  endtask

  task automatic test_align();
    apply_reset(32'h6);
    mem_wait     = 0;
    tb_ready     = 1'b1;
    redir_target = 32'h10;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 8; i++) begin
      tb_redirect = (i == 4);
      cycle();
      if (i >= 1 && i <= 4) begin
        checks++;
        if (s_fault !== 1'b1 || s_en !== 1'b0) begin
          failures++;
          $display("FAIL align_fault: got fault %b en %b expected 1 0 (cycle %0d)", s_fault, s_en, i);
        end
      end
      if (i == 5) begin
        checks++;
        if (s_fault !== 1'b0) begin
          failures++;
          $display("FAIL align_clear: got %b expected 0", s_fault);
        end
      end
      if (i == 6) begin
        checks++;
        if (s_en !== 1'b1 || s_addr !== 32'h10 || s_adv !== 1'b1) begin
          failures++;
          $display("FAIL align_resume: got en %b addr %h adv %b expected 1 10 1", s_en, s_addr, s_adv);
        end
      end
    end
    tb_redirect = 1'b0;
`else
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (s_fault !== 1'b0) begin
        failures++;
        $display("FAIL align_tied: got %b expected 0", s_fault);
      end
      if (i == 1) begin
        checks++;
        if (s_en !== 1'b1 || s_addr !== 32'h6) begin
          failures++;
          $display("FAIL align_passthru: got en %b addr %h expected 1 6", s_en, s_addr);
        end
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset(32'h0);
    mem_wait = 5;
    tb_ready = 1'b1;
    cycle();
    cycle();
    checks++;
    if (s_en !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_req: got %b expected 1", s_en);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_enable !== 1'b0 || bus.pc_advance !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async: got en %b adv %b expected 0 0", bus.mem_enable, bus.pc_advance);
    end
    @(posedge clk);
    #1;
    sb.delete();
    drain    = 1'b0;
    wcnt     = 0;
    pc_model = 32'h100;
    reset    = 1'b0;
    tb_force_ack = 1'b1;
    cycle();
    tb_force_ack = 1'b0;
    mem_wait = 0;
    checks++;
    if (s_adv !== 1'b0) begin
      failures++;
      $display("FAIL rst_late_ack_adv: got %b expected 0", s_adv);
    end
    cycle();
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_late_ack_push: got %b expected 0", s_valid);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset(32'h1000);
    mem_wait = $urandom_range(0, 2);
    for (int i = 0; i < 60; i++) begin
      tb_ready     = 1'($urandom_range(0, 1));
      tb_redirect  = (i % 13 == 12);
      redir_target = 32'h2000 + 32'(i) * 32'd16;
      cycle();
    end
    tb_redirect = 1'b0;
    mem_wait    = 0;
    tb_ready    = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    drain        = 1'b0;
    wcnt         = 0;
    mem_wait     = 0;
    pc_model     = 32'h0;
    redir_target = 32'h0;
    tb_redirect  = 1'b0;
    tb_ready     = 1'b0;
    tb_force_ack = 1'b0;
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_drain();
    test_redirect_ack();
    test_align();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: AW, 32, PC and memory address width in bits.
REQ-002 Parameter: IW, 32, instruction and memory data width in bits.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 pc_in  in  AW  current fetch PC (new_pc from the pc block).
REQ-006 pc_advance  out  1  one-cycle pulse; the pc block steps to the sequential PC.
REQ-007 redirect  in  1  taken jump, branch or exception; flushes fetch.
REQ-008 mem_enable  out  1  memory request strobe.
REQ-009 mem_rw  out  1  read/write select; constant 0 (read).
REQ-010 mem_ack  in  1  memory response; data valid in the same cycle.
REQ-011 mem_addr  out  AW  request address.
REQ-012 mem_data_out  in  IW  read data from memory.
REQ-013 inst  out  IW  instruction at the queue head.
REQ-014 inst_pc  out  AW  PC of the queue-head instruction.
REQ-015 inst_valid  out  1  queue non-empty.
REQ-016 inst_ready  in  1  decode accepts the head entry.
REQ-017 fetch_fault  out  1  misaligned fetch PC detected.

Function
REQ-018 FSM states: IDLE, REQ, DRAIN.
REQ-019 IDLE->REQ when queue count <= 1, redirect = 0 and no fault is pending; mem_addr <= pc_in on that edge.
REQ-020 mem_enable = 1 in REQ and DRAIN, 0 in IDLE; mem_addr is held stable while mem_enable = 1.
REQ-021 Exactly one request is outstanding at a time; mem_ack is ignored in IDLE.
REQ-022 REQ with mem_ack=1 and redirect=0: push {mem_addr, mem_data_out} into the queue, pulse pc_advance combinationally in that cycle, go to IDLE.
REQ-023 After an ack the FSM passes through IDLE for one cycle, so the next request uses the updated pc_in; peak throughput is one instruction per 2 cycles.
REQ-024 The pushed entry is visible on inst/inst_valid the cycle after mem_ack.
REQ-025 Queue: 2-entry FIFO; pop when inst_valid & inst_ready; a push and a pop in the same cycle are both honoured; the FSM never pushes when the queue is full.
REQ-026 redirect=1: queue count <= 0 on the next edge; pc_advance = 0 in that cycle.
REQ-027 redirect=1 in REQ without mem_ack: go to DRAIN; keep the request until mem_ack, discard the data, go to IDLE.
REQ-028 redirect=1 coincident with mem_ack (REQ or DRAIN): discard the data, go to IDLE.
REQ-029 redirect has priority over pop; inst_valid = 0 the cycle after redirect.
REQ-030 mem_rw = 0 at all times.

Reset
REQ-031 While reset = 1: state IDLE, queue empty, and mem_enable, pc_advance, inst_valid, fetch_fault, mem_addr, inst and inst_pc all 0.
REQ-032 Reset mid-request drops mem_enable immediately (asynchronous); a later mem_ack from the abandoned request is ignored.

Configuration
REQ-033 Macro FETCH_ALIGN_CHECK_EN.
REQ-034 Macro defined: an IDLE->REQ attempt with pc_in[1:0] != 0 issues no request and sets fetch_fault.
REQ-035 Macro defined: fetch_fault is sticky and blocks issue until redirect or reset clears it.
REQ-036 Macro undefined: fetch_fault is tied to 0, and pc_in is passed to mem_addr unchanged.

Verification
REQ-037 Zero-wait memory, pc_in 0x0 then 0x4, inst_ready=1: ack and pc_advance in cycles 1 and 3; inst_pc 0x0 and 0x4 valid in cycles 2 and 4.
REQ-038 inst_ready=0 with 3 PCs offered: exactly 2 entries queued, mem_enable stays 0; one pop re-enables issue on the next cycle.
REQ-039 Request at 0x8 with ack after 3 wait cycles, redirect in wait cycle 1: DRAIN held, data discarded, no pc_advance, next request uses the redirected pc_in 0x40.
REQ-040 Redirect coincident with mem_ack while 1 entry is queued: queue empty next cycle, inst_valid=0, no push.
REQ-041 With FETCH_ALIGN_CHECK_EN, pc_in=0x6: fetch_fault=1, mem_enable stays 0 until redirect to 0x10; fetch then resumes at 0x10.
REQ-042 reset asserted during REQ: mem_enable=0 in the same cycle; a mem_ack that arrives later causes no push.
